// File: rtl/sr_rw_ctrl_if.sv
// Host-side handshake of the shift-register read/write controller:
// write word and start request in, busy/done status and readback word out.
interface sr_rw_ctrl_if #(
    parameter int DATA_WIDTH = 170
) ();
    logic [DATA_WIDTH-1:0] din;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output din,
        output start,
        input  busy,
        input  done,
        input  dout
    );

    modport slave (
        input  din,
        input  start,
        output busy,
        output done,
        output dout
    );
endinterface

// File: rtl/sr_rw_ctrl.sv
// Serialises a latched word into a configuration shift-register chain with a divided
// shift clock, captures the chain's readback, then pulses load and reports the readback.
module sr_rw_ctrl #(
    parameter int DATA_WIDTH      = 170,
    parameter int CNT_WIDTH       = 8,
    parameter int SHIFT_DIRECTION = 1,
    parameter int CLK_DIV         = 2,
    parameter int DIV_WIDTH       = 4
) (
    input  logic             clk,
    input  logic             rst,
    sr_rw_ctrl_if.slave      host,
    output logic             sr_clk,
    output logic             sr_data_out,
    input  logic             sr_data_in,
    output logic             sr_load
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  BIT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [DIV_WIDTH-1:0]  DIV_LAST = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] wr, wr_n;
    logic [DATA_WIDTH-1:0] rd, rd_n;
    logic [CNT_WIDTH-1:0]  bit_cnt, bit_n;
    logic [DIV_WIDTH-1:0]  div_cnt, div_n;
    logic [DATA_WIDTH-1:0] dout_q, dout_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic                  sr_clk_n, sr_data_out_n, sr_load_n;

    logic                  phase_end;
    logic [CNT_WIDTH-1:0]  in_idx, out_idx;
    logic [DATA_WIDTH-1:0] wr_shifted;

    assign host.busy = busy_q;
    assign host.done = done_q;
    assign host.dout = dout_q;

    always_comb begin
        state_n   = state;
        wr_n      = wr;
        rd_n      = rd;
        bit_n     = bit_cnt;
        div_n     = div_cnt;
        dout_n    = dout_q;
        done_n    = 1'b0;
        phase_end = (div_cnt == DIV_LAST);
        in_idx    = (SHIFT_DIRECTION != 0) ? (BIT_LAST - bit_cnt) : bit_cnt;

        case (state)
            IDLE: begin
                if (host.start) begin
                    wr_n    = host.din;
                    bit_n   = '0;
                    div_n   = '0;
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    // Bit-position write via masks keeps the index width independent of DATA_WIDTH.
                    rd_n    = (rd & ~(ONE << in_idx))
                              | (DATA_WIDTH'(sr_data_in) << in_idx);
                    div_n   = '0;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div_cnt + DIV_WIDTH'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    div_n   = '0;
                    bit_n   = bit_cnt + CNT_WIDTH'(1);
                    state_n = (bit_cnt == BIT_LAST) ? LOAD : SHIFT_LO;
                end else begin
                    div_n = div_cnt + DIV_WIDTH'(1);
                end
            end
            LOAD: begin
                if (phase_end) begin
                    div_n   = '0;
                    dout_n  = rd;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    div_n = div_cnt + DIV_WIDTH'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight from flops.
        out_idx       = (SHIFT_DIRECTION != 0) ? (BIT_LAST - bit_n) : bit_n;
        wr_shifted    = wr_n >> out_idx;
        busy_n        = (state_n != IDLE);
        sr_clk_n      = (state_n == SHIFT_HI);
        sr_load_n     = (state_n == LOAD);
        sr_data_out_n = ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) ? wr_shifted[0] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr          <= '0;
            rd          <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            dout_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sr_clk      <= 1'b0;
            sr_data_out <= 1'b0;
            sr_load     <= 1'b0;
        end else begin
            state       <= state_n;
            wr          <= wr_n;
            rd          <= rd_n;
            bit_cnt     <= bit_n;
            div_cnt     <= div_n;
            dout_q      <= dout_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            sr_clk      <= sr_clk_n;
            sr_data_out <= sr_data_out_n;
            sr_load     <= sr_load_n;
        end
    end

endmodule

// File: tb/tb_sr_rw_ctrl.sv
// Scoreboard bench for sr_rw_ctrl: three 8-bit instances (MSB-first div 2, LSB-first div 2,
// MSB-first div 1) with loopback or a modelled chain on the serial side.
module tb_sr_rw_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sr_rw_ctrl_if #(.DATA_WIDTH(8)) bus_msb ();
    sr_rw_ctrl_if #(.DATA_WIDTH(8)) bus_lsb ();
    sr_rw_ctrl_if #(.DATA_WIDTH(8)) bus_fast ();

    logic msb_clk, msb_sdo, msb_sdi, msb_load;
    logic lsb_clk, lsb_sdo, lsb_sdi, lsb_load;
    logic fast_clk, fast_sdo, fast_sdi, fast_load;

    sr_rw_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(8), .SHIFT_DIRECTION(1), .CLK_DIV(2), .DIV_WIDTH(4)) u_msb (
        .clk(clk), .rst(rst), .host(bus_msb.slave),
        .sr_clk(msb_clk), .sr_data_out(msb_sdo), .sr_data_in(msb_sdi), .sr_load(msb_load));

    sr_rw_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(8), .SHIFT_DIRECTION(0), .CLK_DIV(2), .DIV_WIDTH(4)) u_lsb (
        .clk(clk), .rst(rst), .host(bus_lsb.slave),
        .sr_clk(lsb_clk), .sr_data_out(lsb_sdo), .sr_data_in(lsb_sdi), .sr_load(lsb_load));

    sr_rw_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(8), .SHIFT_DIRECTION(1), .CLK_DIV(1), .DIV_WIDTH(4)) u_fast (
        .clk(clk), .rst(rst), .host(bus_fast.slave),
        .sr_clk(fast_clk), .sr_data_out(fast_sdo), .sr_data_in(fast_sdi), .sr_load(fast_load));

    // Chain model: shifts toward its tail on each sr_clk rise; tail feeds back as readback.
    logic [7:0] chain, chain_init;
    logic       chain_pre = 1'b0;
    logic       use_chain = 1'b0;
    always @(posedge msb_clk or posedge chain_pre)
        if (chain_pre) chain <= chain_init;
        else           chain <= {chain[6:0], msb_sdo};

    assign msb_sdi  = use_chain ? chain[7] : msb_sdo;
    assign lsb_sdi  = lsb_sdo;
    assign fast_sdi = fast_sdo;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] q_msb[$];
    logic [7:0] q_lsb[$];
    logic [7:0] q_fast[$];

    int unsigned m_busy = 0, m_rise = 0, m_load = 0, m_done = 0, m_ovl = 0;
    logic        m_prev_clk = 1'b0, m_prev_load = 1'b0;
    logic [31:0] m_trace = '0;
    logic [7:0]  chain_at_load = '0;
    always @(negedge clk) begin
        if (bus_msb.busy) m_busy++;
        if (msb_clk && !m_prev_clk) m_rise++;
        if (msb_load) m_load++;
        if (msb_load && msb_clk) m_ovl++;
        if (msb_load && !m_prev_load) chain_at_load = chain;
        if (bus_msb.busy && !msb_load) m_trace = {m_trace[30:0], msb_sdo};
        if (bus_msb.done) begin
            m_done++;
            check("msb_sb_pending", 32'(q_msb.size() != 0), 32'd1);
            if (q_msb.size() != 0) check("msb_dout", 32'(bus_msb.dout), 32'(q_msb.pop_front()));
        end
        m_prev_clk  = msb_clk;
        m_prev_load = msb_load;
    end

    int unsigned l_rise = 0, l_done = 0;
    logic        l_prev_clk = 1'b0;
    logic [7:0]  l_bits = '0;
    always @(negedge clk) begin
        if (lsb_clk && !l_prev_clk) begin
            l_rise++;
            l_bits = {l_bits[6:0], lsb_sdo};
        end
        if (bus_lsb.done) begin
            l_done++;
            check("lsb_sb_pending", 32'(q_lsb.size() != 0), 32'd1);
            if (q_lsb.size() != 0) check("lsb_dout", 32'(bus_lsb.dout), 32'(q_lsb.pop_front()));
        end
        l_prev_clk = lsb_clk;
    end

    int unsigned f_busy = 0, f_rise = 0, f_high = 0, f_done = 0, f_ovl = 0;
    int unsigned f_done_t[4];
    logic        f_prev_clk = 1'b0;
    always @(negedge clk) begin
        if (bus_fast.busy) f_busy++;
        if (fast_clk) f_high++;
        if (fast_clk && !f_prev_clk) f_rise++;
        if (fast_clk && fast_load) f_ovl++;
        if (bus_fast.done) begin
            if (f_done < 4) f_done_t[f_done] = cyc;
            f_done++;
            check("fast_sb_pending", 32'(q_fast.size() != 0), 32'd1);
            if (q_fast.size() != 0) check("fast_dout", 32'(bus_fast.dout), 32'(q_fast.pop_front()));
        end
        f_prev_clk = fast_clk;
    end

    task automatic run_msb(input logic [7:0] d, input logic [7:0] exp);
        @(negedge clk);
        bus_msb.din   = d;
        bus_msb.start = 1'b1;
        q_msb.push_back(exp);
        @(negedge clk);
        bus_msb.start = 1'b0;
    endtask

    task automatic wait_msb_done(input int unsigned base);
        for (int i = 0; i < 300 && m_done == base; i++) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned b_busy, b_rise, b_load, b_done, b_ovl, seen, r;
        logic [31:0] exp_trace;
        logic [7:0]  d;
        logic        prev;

        bus_msb.din = '0;  bus_msb.start = 1'b0;
        bus_lsb.din = '0;  bus_lsb.start = 1'b0;
        bus_fast.din = '0; bus_fast.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outs", 32'({bus_msb.busy, bus_msb.done, msb_clk, msb_sdo, msb_load}), 32'd0);
        check("rst_dout", 32'(bus_msb.dout), 32'd0);
        rst = 1'b0;

        // 1: MSB-first loopback of A5
        b_busy = m_busy; b_rise = m_rise; b_load = m_load; b_done = m_done; b_ovl = m_ovl;
        d = 8'hA5;
        exp_trace = '0;
        for (int i = 7; i >= 0; i--)
            for (int j = 0; j < 4; j++) exp_trace = {exp_trace[30:0], d[i]};
        run_msb(d, d);
        wait_msb_done(b_done);
        repeat (4) @(negedge clk);
        check("t1_trace", m_trace, exp_trace);
        check("t1_rises", m_rise - b_rise, 32'd8);
        check("t1_busy",  m_busy - b_busy, 32'd34);
        check("t1_load",  m_load - b_load, 32'd2);
        check("t1_done",  m_done - b_done, 32'd1);
        check("t1_overlap", m_ovl - b_ovl, 32'd0);

        // 2: LSB-first loopback of 01
        @(negedge clk);
        bus_lsb.din = 8'h01; bus_lsb.start = 1'b1; q_lsb.push_back(8'h01);
        @(negedge clk);
        bus_lsb.start = 1'b0;
        for (int i = 0; i < 300 && l_done == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t2_bits_order", 32'(l_bits), 32'h80);
        check("t2_rises", l_rise, 32'd8);
        check("t2_done", l_done, 32'd1);

        // 3: readback from a modelled chain preloaded with 3C
        chain_init = 8'h3C;
        chain_pre = 1'b1; #1 chain_pre = 1'b0;
        use_chain = 1'b1;
        b_done = m_done;
        run_msb(8'hFF, 8'h3C);
        wait_msb_done(b_done);
        repeat (2) @(negedge clk);
        check("t3_chain_at_load", 32'(chain_at_load), 32'hFF);
        check("t3_done", m_done - b_done, 32'd1);
        use_chain = 1'b0;

        // 4: start pulse mid-transaction is ignored
        b_busy = m_busy; b_done = m_done;
        run_msb(8'h96, 8'h96);
        repeat (9) @(negedge clk);
        bus_msb.din = 8'h00; bus_msb.start = 1'b1;
        @(negedge clk);
        bus_msb.start = 1'b0;
        wait_msb_done(b_done);
        repeat (6) @(negedge clk);
        check("t4_busy", m_busy - b_busy, 32'd34);
        check("t4_done", m_done - b_done, 32'd1);
        check("t4_sb_empty", 32'(q_msb.size()), 32'd0);

        // 5: asynchronous reset during the high phase of bit 3
        run_msb(8'h33, 8'h33);
        r = 1; prev = 1'b0;
        for (int i = 0; i < 100 && r < 4; i++) begin
            @(negedge clk);
            if (msb_clk && !prev) r++;
            prev = msb_clk;
        end
        check("t5_reach_hi", r, 32'd4);
        check("t5_in_hi", 32'(msb_clk), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_outs", 32'({bus_msb.busy, bus_msb.done, msb_clk, msb_sdo, msb_load}), 32'd0);
        check("t5_rst_dout", 32'(bus_msb.dout), 32'd0);
        q_msb.delete();
        @(negedge clk);
        rst = 1'b0;
        b_done = m_done;
        run_msb(8'h5A, 8'h5A);
        wait_msb_done(b_done);
        repeat (2) @(negedge clk);
        check("t5_done", m_done - b_done, 32'd1);

        // 6: CLK_DIV=1, start held for three back-to-back transactions
        bus_fast.din = 8'hC3;
        repeat (3) q_fast.push_back(8'hC3);
        @(negedge clk);
        bus_fast.start = 1'b1;
        seen = 0;
        for (int i = 0; i < 300 && seen < 3; i++) begin
            @(negedge clk);
            if (bus_fast.done) seen++;
        end
        bus_fast.start = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_done", f_done, 32'd3);
        check("t6_gap1", f_done_t[1] - f_done_t[0], 32'd18);
        check("t6_gap2", f_done_t[2] - f_done_t[1], 32'd18);
        check("t6_rises", f_rise, 32'd24);
        check("t6_high_cycles", f_high, 32'd24);
        check("t6_busy", f_busy, 32'd51);
        check("t6_overlap", f_ovl, 32'd0);

        check("end_sb_msb",  32'(q_msb.size()), 32'd0);
        check("end_sb_lsb",  32'(q_lsb.size()), 32'd0);
        check("end_sb_fast", 32'(q_fast.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
